// File: rtl/flappy_pkg.sv
// Shared Flappy Bird constants: one-hot game states, screen size and coordinate widths.
package flappy_pkg;

    localparam int X_W      = 11;
    localparam int Y_W      = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        HIT  = 3'b100
    } state_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/flappy_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); exposes the low OUT_W bits.
module flappy_lfsr #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic [OUT_W-1:0] rnd
);

    logic [15:0] lfsr;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            lfsr <= SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign rnd = lfsr[OUT_W-1:0];

endmodule

// File: rtl/pipe_engine.sv
// Flappy Bird obstacle engine: scrolls two pipes, randomises gaps, scores and detects hits.
// Define PIPE_SPEEDUP_EN to raise the scroll step by one every 8 points (capped at +3).
module pipe_engine
    import flappy_pkg::*;
#(
    parameter int          PIPE_W       = 52,
    parameter int          PIPE_SPACING = 320,
    parameter int          GAP_H        = 120,
    parameter int          GAP_MIN      = 40,
    parameter int          BIRD_SIZE    = 16,
    parameter int          SCROLL_STEP  = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Ack,
    input  logic        Frame_Tick,
    input  logic [9:0]  XBird,
    input  logic [9:0]  YBird,
    output logic [10:0] Pipe0_X,
    output logic [9:0]  Pipe0_GapY,
    output logic [10:0] Pipe1_X,
    output logic [9:0]  Pipe1_GapY,
    output logic [7:0]  Score,
    output logic        Hit,
    output logic        q_Idle,
    output logic        q_Run,
    output logic        q_Hit
);

    state_t state, state_nxt;

    logic [1:0][10:0] px, nxt_x, moved;
    logic [1:0][9:0]  gy, nxt_gy;
    logic [1:0]       hit_pipe, respawn, passed;
    logic [7:0]       score;
    logic [7:0]       rnd;
    logic [10:0]      step;
    logic [9:0]       new_gap;
    logic [11:0]      bird_x, bird_right;
    logic [10:0]      bird_bot;
    logic             floor_hit, any_hit;

    flappy_lfsr #(.SEED(LFSR_SEED), .OUT_W(8)) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .rnd   (rnd)
    );

`ifdef PIPE_SPEEDUP_EN
    // Step is taken from the current score, before this cycle's increment.
    assign step = 11'(SCROLL_STEP) + ((|score[7:5]) ? 11'd3 : {9'd0, score[4:3]});
`else
    assign step = 11'(SCROLL_STEP);
`endif

    assign new_gap    = 10'(GAP_MIN) + {2'd0, rnd};
    assign bird_x     = {2'd0, XBird};
    assign bird_right = bird_x + 12'(BIRD_SIZE);
    assign bird_bot   = {1'b0, YBird} + 11'(BIRD_SIZE);
    assign floor_hit  = bird_bot >= 11'(SCREEN_H);

    for (genvar k = 0; k < 2; k++) begin : g_pipe
        logic [11:0] x_right;
        logic [10:0] gap_bot;
        assign x_right     = {1'b0, px[k]} + 12'(PIPE_W);
        assign gap_bot     = {1'b0, gy[k]} + 11'(GAP_H);
        assign hit_pipe[k] = (bird_right > {1'b0, px[k]}) && (bird_x < x_right) &&
                             ((YBird < gy[k]) || (bird_bot > gap_bot));
        assign moved[k]    = px[k] - step;
        assign respawn[k]  = px[k] < step;
        // A respawned pipe lines up behind the other pipe's scrolled position.
        assign nxt_x[k]    = respawn[k] ? moved[1-k] + 11'(PIPE_SPACING) : moved[k];
        assign nxt_gy[k]   = respawn[k] ? new_gap : gy[k];
        assign passed[k]   = (x_right >= bird_x) && (({1'b0, nxt_x[k]} + 12'(PIPE_W)) < bird_x);
    end

    assign any_hit = (|hit_pipe) || floor_hit;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = Start ? RUN : IDLE;
            RUN:     state_nxt = any_hit ? HIT : RUN;
            HIT:     state_nxt = Ack ? IDLE : HIT;
            default: state_nxt = IDLE;
        endcase
    end

    // Leaving HIT re-initialises immediately so IDLE is entered with a clean board.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            px[0] <= 11'(SCREEN_W);
            px[1] <= 11'(SCREEN_W + PIPE_SPACING);
            gy    <= {2{10'(GAP_MIN)}};
            score <= 8'd0;
        end else if (state == RUN) begin
            if (!any_hit && Frame_Tick) begin
                px    <= nxt_x;
                gy    <= nxt_gy;
                score <= sat_add8(score, {1'b0, passed[0]} + {1'b0, passed[1]});
            end
        end else if (state != HIT || Ack) begin
            px[0] <= 11'(SCREEN_W);
            px[1] <= 11'(SCREEN_W + PIPE_SPACING);
            gy    <= {2{10'(GAP_MIN)}};
            score <= 8'd0;
        end
    end

    assign Pipe0_X    = px[0];
    assign Pipe1_X    = px[1];
    assign Pipe0_GapY = gy[0];
    assign Pipe1_GapY = gy[1];
    assign Score      = score;
    assign q_Idle     = (state == IDLE);
    assign q_Run      = (state == RUN);
    assign q_Hit      = (state == HIT);
    assign Hit        = q_Hit;

endmodule

// File: tb/tb_pipe_engine.sv
// Directed bench for pipe_engine: reset, scrolling, scoring, respawn, collision and floor.
module tb_pipe_engine;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Ack = 1'b0;
    logic        Frame_Tick = 1'b0;
    logic [9:0]  XBird = 10'd100;
    logic [9:0]  YBird = 10'd100;
    logic [10:0] Pipe0_X, Pipe1_X;
    logic [9:0]  Pipe0_GapY, Pipe1_GapY;
    logic [7:0]  Score;
    logic        Hit, q_Idle, q_Run, q_Hit;

    int pass_cnt = 0;
    int total = 0;
    logic [15:0] lfsr_m;
    logic [9:0]  exp_gap;

    pipe_engine dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Ack        (Ack),
        .Frame_Tick (Frame_Tick),
        .XBird      (XBird),
        .YBird      (YBird),
        .Pipe0_X    (Pipe0_X),
        .Pipe0_GapY (Pipe0_GapY),
        .Pipe1_X    (Pipe1_X),
        .Pipe1_GapY (Pipe1_GapY),
        .Score      (Score),
        .Hit        (Hit),
        .q_Idle     (q_Idle),
        .q_Run      (q_Run),
        .q_Hit      (q_Hit)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR: seed 16'hACE1, taps 16,14,13,11, shifts every clock.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset)
            lfsr_m <= 16'hACE1;
        else
            lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic tick(input int n);
        repeat (n) begin
            Frame_Tick = 1'b1;
            @(negedge Clk);
        end
        Frame_Tick = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        @(negedge Clk);
        total++; if ({q_Idle, q_Run, q_Hit} !== 3'b100) $display("FAIL reset_state: got %b exp 100", {q_Idle, q_Run, q_Hit}); else pass_cnt++;
        total++; if ({Pipe0_X, Pipe1_X} !== {11'd640, 11'd960}) $display("FAIL reset_x: got %0d/%0d exp 640/960", Pipe0_X, Pipe1_X); else pass_cnt++;
        total++; if ({Pipe0_GapY, Pipe1_GapY} !== {10'd40, 10'd40}) $display("FAIL reset_gap: got %0d/%0d exp 40/40", Pipe0_GapY, Pipe1_GapY); else pass_cnt++;
        total++; if ({Score, Hit} !== 9'd0) $display("FAIL reset_score_hit: got %0d/%b exp 0/0", Score, Hit); else pass_cnt++;
        Reset = 1'b1;
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        tick(170);
        total++; if (Pipe0_X !== 11'd300) $display("FAIL midrun_x: got %0d exp 300", Pipe0_X); else pass_cnt++;
        #2 Reset = 1'b0;
        #1;
        total++; if ({q_Idle, Pipe0_X, Pipe1_X, Score} !== {1'b1, 11'd640, 11'd960, 8'd0})
            $display("FAIL async_reset: got idle=%b x=%0d/%0d score=%0d exp 1 640/960 0", q_Idle, Pipe0_X, Pipe1_X, Score); else pass_cnt++;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_start();
        Start = 1'b1;
        Ack   = 1'b1;
        #1;
        total++; if (q_Idle !== 1'b1) $display("FAIL start_latency: got idle=%b exp 1", q_Idle); else pass_cnt++;
        @(negedge Clk);
        Start = 1'b0;
        Ack   = 1'b0;
        total++; if ({q_Run, Hit} !== 2'b10) $display("FAIL start_run: got run=%b hit=%b exp 1/0", q_Run, Hit); else pass_cnt++;
    endtask

    task automatic test_scroll();
        tick(200);
        total++; if ({Pipe0_X, Pipe1_X} !== {11'd240, 11'd560}) $display("FAIL scroll_x: got %0d/%0d exp 240/560", Pipe0_X, Pipe1_X); else pass_cnt++;
        total++; if ({Hit, Score} !== 9'd0) $display("FAIL scroll_hit_score: got %b/%0d exp 0/0", Hit, Score); else pass_cnt++;
    endtask

    task automatic test_score();
        tick(96);
        total++; if ({Pipe0_X, Score} !== {11'd48, 8'd0}) $display("FAIL score_before: got x=%0d score=%0d exp 48/0", Pipe0_X, Score); else pass_cnt++;
        tick(1);
        total++; if ({Pipe0_X, Score, Hit} !== {11'd46, 8'd1, 1'b0}) $display("FAIL score_pass: got x=%0d score=%0d hit=%b exp 46/1/0", Pipe0_X, Score, Hit); else pass_cnt++;
    endtask

    task automatic test_respawn();
        tick(23);
        total++; if ({Pipe0_X, Pipe1_X} !== {11'd0, 11'd320}) $display("FAIL pre_respawn: got %0d/%0d exp 0/320", Pipe0_X, Pipe1_X); else pass_cnt++;
        exp_gap = 10'd40 + {2'd0, lfsr_m[7:0]};
        tick(1);
        total++; if ({Pipe0_X, Pipe1_X} !== {11'd638, 11'd318}) $display("FAIL respawn_x: got %0d/%0d exp 638/318", Pipe0_X, Pipe1_X); else pass_cnt++;
        total++; if ({Pipe0_GapY, Pipe1_GapY} !== {exp_gap, 10'd40}) $display("FAIL respawn_gap: got %0d/%0d exp %0d/40", Pipe0_GapY, Pipe1_GapY, exp_gap); else pass_cnt++;
        total++; if (Score !== 8'd1) $display("FAIL respawn_score: got %0d exp 1", Score); else pass_cnt++;
    endtask

    task automatic test_hit();
        tick(114);
        total++; if ({Pipe1_X, Pipe0_X, Hit} !== {11'd90, 11'd410, 1'b0}) $display("FAIL hit_setup: got %0d/%0d hit=%b exp 90/410/0", Pipe1_X, Pipe0_X, Hit); else pass_cnt++;
        YBird      = 10'd20;
        Frame_Tick = 1'b1;
        #1;
        total++; if (Hit !== 1'b0) $display("FAIL hit_latency: got %b exp 0", Hit); else pass_cnt++;
        @(negedge Clk);
        Frame_Tick = 1'b0;
        total++; if ({Hit, q_Hit} !== 2'b11) $display("FAIL hit_state: got %b/%b exp 1/1", Hit, q_Hit); else pass_cnt++;
        total++; if ({Pipe1_X, Pipe0_X, Score} !== {11'd90, 11'd410, 8'd1}) $display("FAIL hit_freeze: got %0d/%0d score=%0d exp 90/410/1", Pipe1_X, Pipe0_X, Score); else pass_cnt++;
        Start = 1'b1;
        tick(3);
        Start = 1'b0;
        total++; if ({q_Hit, Pipe1_X} !== {1'b1, 11'd90}) $display("FAIL hit_hold: got hit=%b x=%0d exp 1/90", q_Hit, Pipe1_X); else pass_cnt++;
        Start = 1'b1;
        Ack   = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Ack   = 1'b0;
        total++; if ({q_Idle, Hit, Score} !== {1'b1, 1'b0, 8'd0}) $display("FAIL ack_idle: got idle=%b hit=%b score=%0d exp 1/0/0", q_Idle, Hit, Score); else pass_cnt++;
        total++; if ({Pipe0_X, Pipe1_X, Pipe0_GapY} !== {11'd640, 11'd960, 10'd40}) $display("FAIL ack_geom: got %0d/%0d gap=%0d exp 640/960/40", Pipe0_X, Pipe1_X, Pipe0_GapY); else pass_cnt++;
    endtask

    task automatic test_floor();
        YBird = 10'd463;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Ack   = 1'b1;
        @(negedge Clk);
        Ack   = 1'b0;
        total++; if ({q_Run, Hit} !== 2'b10) $display("FAIL floor_463: got run=%b hit=%b exp 1/0", q_Run, Hit); else pass_cnt++;
        YBird = 10'd464;
        @(negedge Clk);
        total++; if ({q_Hit, Hit} !== 2'b11) $display("FAIL floor_464: got q_hit=%b hit=%b exp 1/1", q_Hit, Hit); else pass_cnt++;
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        total++; if ({q_Idle, q_Run, q_Hit} !== 3'b100) $display("FAIL floor_ack: got %b exp 100", {q_Idle, q_Run, q_Hit}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_scroll();
        test_score();
        test_respawn();
        test_hit();
        test_floor();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
